// File: rtl/dmem_stage_param.sv
// dmem_stage_param: data-memory pipeline stage with configurable access latency.
// Optional macro DMEM_WB_BYPASS_EN forwards writeback data into store data.
`default_nettype none

module dmem_stage_param #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic                  mem_read,
    input  logic                  mem_we,
    input  logic                  link,
    input  logic [1:0]            access_size,
    input  logic                  sign_ext,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [31:0]           mem_data_in,
    input  logic [4:0]            rt_in,
    input  logic [4:0]            rd_in,
    input  logic                  wb_we,
    input  logic [4:0]            wb_rd,
    input  logic [31:0]           wb_data,
    output logic                  stall,
    output logic                  valid_out,
    output logic [4:0]            rd_out,
    output logic [31:0]           rd_data_out,
    output logic                  misalign
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0] state;
    logic [2:0] count;

    logic [31:0] mem [DEPTH_WORDS];

    // Operands captured at acceptance, replayed for the whole multi-cycle access.
    logic                  cap_read, cap_we, cap_link, cap_sext;
    logic [1:0]            cap_size;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [31:0]           cap_data;
    logic [4:0]            cap_rd;

    logic                  accept, go_busy, finish_now;
    logic                  op_read, op_we, op_link, op_sext, op_mem;
    logic [1:0]            op_size;
    logic [ADDR_WIDTH-1:0] op_addr;
    logic [31:0]           op_data;
    logic [4:0]            op_rd;
    logic [31:0]           in_data;
    logic [IDX_W-1:0]      idx;
    logic [1:0]            off;
    logic                  is_byte, is_half, misal;
    logic [31:0]           word_rd, lane_word, load_val, result, wdata, addr_ext;
    logic [4:0]            shamt;
    logic [3:0]            be;

`ifdef DMEM_WB_BYPASS_EN
    assign in_data = (mem_we && wb_we && (wb_rd != 5'd0) && (wb_rd == rt_in)) ? wb_data : mem_data_in;
`else
    logic unused_bypass;
    assign unused_bypass = ^{wb_we, wb_rd, wb_data, rt_in};
    assign in_data       = mem_data_in;
`endif

    generate
        if (ADDR_WIDTH >= 32) begin : g_addr_wide
            assign addr_ext = op_addr[31:0];
        end else begin : g_addr_narrow
            assign addr_ext = {{(32-ADDR_WIDTH){1'b0}}, op_addr};
        end
    endgenerate

    assign accept     = (state == S_IDLE) && valid_in;
    assign go_busy    = accept && (mem_read || mem_we) && (MEM_LATENCY > 1);
    assign finish_now = (accept && !go_busy) || ((state == S_BUSY) && (count == 3'd1));

    always_comb begin
        if (state == S_BUSY) begin
            op_read = cap_read;
            op_we   = cap_we;
            op_link = cap_link;
            op_sext = cap_sext;
            op_size = cap_size;
            op_addr = cap_addr;
            op_data = cap_data;
            op_rd   = cap_rd;
        end else begin
            op_read = mem_read;
            op_we   = mem_we;
            op_link = link;
            op_sext = sign_ext;
            op_size = access_size;
            op_addr = mem_address;
            op_data = in_data;
            op_rd   = rd_in;
        end
    end

    assign op_mem  = op_read || op_we;
    assign idx     = op_addr[IDX_W+1:2];
    assign off     = op_addr[1:0];
    assign is_byte = (op_size == 2'b00);
    assign is_half = (op_size == 2'b01);
    assign misal   = op_mem && ((is_half && off[0]) || (!is_byte && !is_half && (off != 2'b00)));
    assign word_rd = mem[idx];

    // Big-endian lanes: byte offset 0 lives in bits 31:24.
    assign shamt     = {~off, 3'b000};
    assign lane_word = word_rd >> shamt;

    always_comb begin
        load_val = word_rd;
        if (is_byte) begin
            load_val = {{24{op_sext & lane_word[7]}}, lane_word[7:0]};
        end else if (is_half) begin
            load_val = off[1] ? {{16{op_sext & word_rd[15]}}, word_rd[15:0]}
                              : {{16{op_sext & word_rd[31]}}, word_rd[31:16]};
        end
    end

    always_comb begin
        if (op_read) begin
            result = misal ? 32'd0 : load_val;
        end else if (op_link) begin
            result = op_data;
        end else begin
            result = addr_ext;
        end
    end

    always_comb begin
        wdata = op_data;
        be    = 4'b1111;
        if (is_byte) begin
            wdata = {4{op_data[7:0]}};
            be    = 4'b1000 >> off;
        end else if (is_half) begin
            wdata = {2{op_data[15:0]}};
            be    = off[1] ? 4'b0011 : 4'b1100;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && finish_now && op_we && !misal) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cap_read <= mem_read;
            cap_we   <= mem_we;
            cap_link <= link;
            cap_sext <= sign_ext;
            cap_size <= access_size;
            cap_addr <= mem_address;
            cap_data <= in_data;
            cap_rd   <= rd_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            count       <= 3'd0;
            stall       <= 1'b0;
            valid_out   <= 1'b0;
            rd_out      <= 5'd0;
            rd_data_out <= 32'd0;
            misalign    <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go_busy) begin
                        state <= S_BUSY;
                        count <= 3'(MEM_LATENCY - 1);
                        stall <= 1'b1;
                    end
                end
                S_BUSY: begin
                    count <= count - 3'd1;
                    if (count == 3'd1) begin
                        state <= S_IDLE;
                        stall <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (finish_now) begin
                valid_out   <= 1'b1;
                rd_out      <= op_rd;
                rd_data_out <= result;
                misalign    <= misal;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_stage_param.sv
// tb_dmem_stage_param: randomized and directed checks of single-cycle and three-cycle instances.
`default_nettype none

module tb_dmem_stage_param;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        vin1, vin3;
    logic        mem_read, mem_we, link, sign_ext;
    logic [1:0]  access_size;
    logic [31:0] mem_address, mem_data_in;
    logic [4:0]  rt_in, rd_in;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic        stall1, vout1, mis1, stall3, vout3, mis3;
    logic [4:0]  rdo1, rdo3;
    logic [31:0] rdd1, rdd3;

    int passed = 0;
    int total  = 0;

    // Reference memory: key = instance latency * 1_000_000 + word index.
    bit [31:0] model_mem [int];

    always #5 clk = ~clk;

    dmem_stage_param #(.ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .MEM_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .valid_in(vin1), .mem_read(mem_read), .mem_we(mem_we),
        .link(link), .access_size(access_size), .sign_ext(sign_ext), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .rt_in(rt_in), .rd_in(rd_in), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .stall(stall1), .valid_out(vout1), .rd_out(rdo1),
        .rd_data_out(rdd1), .misalign(mis1)
    );

    dmem_stage_param #(.ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .MEM_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .valid_in(vin3), .mem_read(mem_read), .mem_we(mem_we),
        .link(link), .access_size(access_size), .sign_ext(sign_ext), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .rt_in(rt_in), .rd_in(rd_in), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .stall(stall3), .valid_out(vout3), .rd_out(rdo3),
        .rd_data_out(rdd3), .misalign(mis3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic do_access(input int d, input bit rd_, input bit we_, input bit lk,
                             input logic [1:0] sz, input bit se, input logic [31:0] addr,
                             input logic [31:0] data, input logic [4:0] rt, input logic [4:0] rdi,
                             input bit wwe, input logic [4:0] wrd, input logic [31:0] wdat,
                             input string tag);
        bit          memop, mis;
        int          key, sh, cyc, st_cnt, exp_lat;
        bit [31:0]   word, val, sdata, mask, exp_data;
        logic        v, s;
        memop = rd_ || we_;
        mis   = memop && ((sz == 2'b01 && addr[0]) || (sz[1] && addr[1:0] != 2'b00));
        key   = d * 1000000 + int'((addr >> 2) % DEPTH);
        word  = model_mem.exists(key) ? model_mem[key] : 32'h0;
        sdata = data;
`ifdef DMEM_WB_BYPASS_EN
        if (we_ && wwe && wrd != 0 && wrd == rt) sdata = wdat;
`endif
        if (rd_) begin
            if (mis) val = 0;
            else if (sz == 2'b00) begin
                sh  = 8 * (3 - int'(addr % 4));
                val = (word >> sh) & 32'hFF;
                if (se && val[7]) val = val | 32'hFFFF_FF00;
            end else if (sz == 2'b01) begin
                sh  = 8 * (2 - int'(addr % 4));
                val = (word >> sh) & 32'hFFFF;
                if (se && val[15]) val = val | 32'hFFFF_0000;
            end else val = word;
            exp_data = val;
        end else if (lk) exp_data = data;
        else exp_data = addr;
        if (we_ && !mis) begin
            if (sz == 2'b00) begin
                sh = 8 * (3 - int'(addr % 4)); mask = 32'hFF << sh;
                word = (word & ~mask) | ((sdata & 32'hFF) << sh);
            end else if (sz == 2'b01) begin
                sh = 8 * (2 - int'(addr % 4)); mask = 32'hFFFF << sh;
                word = (word & ~mask) | ((sdata & 32'hFFFF) << sh);
            end else word = sdata;
            model_mem[key] = word;
        end
        exp_lat = (d == 3 && memop) ? 3 : 1;

        @(negedge clk);
        mem_read = rd_; mem_we = we_; link = lk; access_size = sz; sign_ext = se;
        mem_address = addr; mem_data_in = data; rt_in = rt; rd_in = rdi;
        wb_we = wwe; wb_rd = wrd; wb_data = wdat;
        if (d == 1) vin1 = 1'b1; else vin3 = 1'b1;
        cyc = 0; st_cnt = 0; v = 1'b0; s = 1'b0;
        while (!v && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
            v = (d == 1) ? vout1 : vout3;
            s = (d == 1) ? stall1 : stall3;
            if (!v && s) st_cnt++;
        end
        check({tag, ".latency"}, cyc, exp_lat);
        check({tag, ".stall_cycles"}, st_cnt, exp_lat - 1);
        check({tag, ".stall_end"}, {31'd0, s}, 32'd0);
        check({tag, ".valid"}, {31'd0, v}, 32'd1);
        check({tag, ".rd"}, (d == 1) ? rdo1 : rdo3, rdi);
        check({tag, ".data"}, (d == 1) ? rdd1 : rdd3, exp_data);
        check({tag, ".misalign"}, {31'd0, (d == 1) ? mis1 : mis3}, {31'd0, mis});
        @(negedge clk);
        vin1 = 1'b0; vin3 = 1'b0;
    endtask

    initial begin
        int kind, d;
        logic [31:0] a, r;
        logic [4:0] rtv;
        reset = 1'b1; vin1 = 0; vin3 = 0; mem_read = 0; mem_we = 0; link = 0;
        access_size = 2'b11; sign_ext = 0; mem_address = 0; mem_data_in = 0;
        rt_in = 0; rd_in = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.valid1", {31'd0, vout1}, 32'd0);
        check("reset.stall3", {31'd0, stall3}, 32'd0);
        check("reset.rd3", {27'd0, rdo3}, 32'd0);
        check("reset.data1", rdd1, 32'd0);
        check("reset.mis3", {31'd0, mis3}, 32'd0);
        @(negedge clk); reset = 1'b0;

        // Fill words 0..15 of both instances so later loads have defined data.
        for (int dd = 0; dd < 2; dd++)
            for (int w = 0; w < 16; w++)
                do_access(dd ? 3 : 1, 0, 1, 0, 2'b11, 0, w * 4, $urandom, 5'd1, 5'd2, 0, 0, 0, "fill");

        do_access(1, 0, 1, 0, 2'b11, 0, 32'h10, 32'hDEADBEEF, 5'd3, 5'd4, 0, 0, 0, "st_word");
        do_access(1, 1, 0, 0, 2'b11, 0, 32'h10, 0, 5'd0, 5'd5, 0, 0, 0, "ld_word");
        do_access(1, 1, 0, 0, 2'b00, 1, 32'h11, 0, 5'd0, 5'd6, 0, 0, 0, "ld_byte_s");
        do_access(1, 1, 0, 0, 2'b00, 0, 32'h11, 0, 5'd0, 5'd7, 0, 0, 0, "ld_byte_u");
        do_access(1, 1, 0, 0, 2'b01, 1, 32'h12, 0, 5'd0, 5'd8, 0, 0, 0, "ld_half_s");
        check("lit.byte_s", (rdd1 === 32'hFFFFBEEF) ? 32'h1 : 32'h0, 32'h1);
        do_access(1, 0, 1, 0, 2'b11, 0, 32'h22, 32'h11111111, 5'd3, 5'd9, 0, 0, 0, "st_misal");
        do_access(1, 1, 0, 0, 2'b11, 0, 32'h20, 0, 5'd0, 5'd10, 0, 0, 0, "ld_after_misal");
        do_access(1, 0, 0, 1, 2'b11, 0, 32'h1234, 32'h408, 5'd0, 5'd31, 0, 0, 0, "link");
        do_access(1, 0, 0, 0, 2'b11, 0, 32'h55, 32'h99, 5'd0, 5'd12, 0, 0, 0, "alu");
        do_access(3, 1, 0, 0, 2'b11, 0, 32'h8, 0, 5'd0, 5'd13, 0, 0, 0, "lat3_load");
        do_access(3, 0, 0, 0, 2'b11, 0, 32'h77, 0, 5'd0, 5'd14, 0, 0, 0, "lat3_alu");
        do_access(1, 0, 1, 0, 2'b11, 0, 32'h30, 32'hAAAA5555, 5'd5, 5'd1, 1, 5'd5, 32'h1234, "byp_hit");
        do_access(1, 1, 0, 0, 2'b11, 0, 32'h30, 0, 5'd0, 5'd2, 0, 0, 0, "byp_hit_rb");
        do_access(1, 0, 1, 0, 2'b11, 0, 32'h30, 32'hAAAA5555, 5'd0, 5'd1, 1, 5'd0, 32'h1234, "byp_r0");
        do_access(1, 1, 0, 0, 2'b11, 0, 32'h30, 0, 5'd0, 5'd2, 0, 0, 0, "byp_r0_rb");

        // Reset while a three-cycle store is in flight: the store must be dropped.
        @(negedge clk);
        mem_read = 0; mem_we = 1; link = 0; access_size = 2'b11; mem_address = 32'h20;
        mem_data_in = 32'hCAFEF00D; rd_in = 5'd3; wb_we = 0; vin3 = 1'b1;
        @(posedge clk); #1;
        check("abort.stall_on", {31'd0, stall3}, 32'd1);
        @(negedge clk); reset = 1'b1; vin3 = 1'b0;
        @(posedge clk); #1;
        check("abort.stall", {31'd0, stall3}, 32'd0);
        check("abort.valid", {31'd0, vout3}, 32'd0);
        check("abort.data", rdd3, 32'd0);
        @(negedge clk); reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort.idle_valid", {31'd0, vout3}, 32'd0);
        do_access(3, 1, 0, 0, 2'b11, 0, 32'h20, 0, 5'd0, 5'd4, 0, 0, 0, "abort_rb");

        for (int i = 0; i < 120; i++) begin
            d    = ($urandom_range(0, 1) == 0) ? 1 : 3;
            kind = $urandom_range(0, 3);
            r    = $urandom;
            rtv  = 5'($urandom_range(0, 31));
            a    = (kind >= 2) ? $urandom : (($urandom & 32'hFFFF_F000) | ($urandom & 32'h3F));
            do_access(d, kind == 0, kind == 1, kind == 2, 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), a, r, rtv, 5'($urandom_range(0, 31)),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 0) ? rtv : 5'd0,
                      $urandom, "rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_stage_param.md
DMEM_STAGE_PARAM -- requirements
Module: dmem_stage_param

Interface
REQ-001 Parameter ADDR_WIDTH, 32, byte-address width of mem_address.
REQ-002 Parameter DEPTH_WORDS, 1024, number of 32-bit words in the internal data array; power of two.
REQ-003 Parameter MEM_LATENCY, 1, cycles from accepted access to result; legal 1..4.
REQ-004 Port clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port valid_in  in  1  instruction present from execute stage.
REQ-007 Port mem_read / mem_we / link  in  1 each  load / store / JAL-link control.
REQ-008 Port access_size  in  2  00 byte, 01 half, 11 word; 10 is treated as word.
REQ-009 Port sign_ext  in  1  loads: 1 sign-extend, 0 zero-extend.
REQ-010 Port mem_address  in  ADDR_WIDTH  byte address, or ALU result for non-memory ops.
REQ-011 Port mem_data_in  in  32  store data (rt), or PC+8 when link=1.
REQ-012 Port rt_in, rd_in  in  5 each  store source register; destination register.
REQ-013 Port wb_we, wb_rd, wb_data  in  1/5/32  writeback-stage write enable, register, data.
REQ-014 Port stall  out  1  high while an access is in flight; upstream holds inputs.
REQ-015 Port valid_out, rd_out, rd_data_out  out  1/5/32  registered result to writeback.
REQ-016 Port misalign  out  1  registered; current result came from a misaligned access.

Function
REQ-017 FSM states IDLE, BUSY; reset state IDLE.
REQ-018 IDLE, valid_in=1, mem_read|mem_we=1, MEM_LATENCY>1: capture inputs, enter BUSY, load counter MEM_LATENCY-1, assert stall.
REQ-019 BUSY: decrement counter each cycle; stall=1; at counter=1 present result next edge, return to IDLE, stall=0.
REQ-020 MEM_LATENCY=1 or non-memory op: result registered on the accepting edge; stall stays 0; no BUSY.
REQ-021 Word index = mem_address[log2(DEPTH_WORDS)+1:2]; upper bits ignored (wrap-around).
REQ-022 Misaligned: half with addr[0]=1, word with addr[1:0]!=0; no array write, load data 0, misalign=1 with result.
REQ-023 Store byte/half writes only addressed lanes, big-endian (byte 0 = bits 31:24); other lanes unchanged.
REQ-024 Store write occurs on the edge the result is presented; exactly once per store.
REQ-025 Load selects addressed lane big-endian, extends per sign_ext to 32 bits.
REQ-026 rd_data_out: load = extended data; link=1 = mem_data_in; otherwise mem_address zero-extended to 32.
REQ-027 Store and non-writing ops still produce valid_out=1 with rd_out=rd_in; writeback gates on its own control.
REQ-028 valid_in ignored while BUSY; inputs captured at acceptance used throughout.
REQ-029 Load after store to same word in consecutive accesses returns newly written data.

Reset
REQ-030 reset=1 at edge: state IDLE, counter 0, stall 0, valid_out 0, rd_out 0, rd_data_out 0, misalign 0.
REQ-031 reset mid-BUSY aborts access; pending store not written.
REQ-032 Data array not cleared by reset; contents undefined until written.

Configuration
REQ-033 Macro DMEM_WB_BYPASS_EN defined: if wb_we=1, wb_rd!=0, wb_rd==rt_in at acceptance, store data = wb_data.
REQ-034 Macro undefined: store data always mem_data_in; wb_we/wb_rd/wb_data unused.

Verification
REQ-035 Word store 0xDEADBEEF at 0x10, word load 0x10 -> rd_data_out=0xDEADBEEF, misalign=0.
REQ-036 Byte load 0x11, sign_ext=1 then 0 -> 0xFFFFFFAD, then 0x000000AD; half load 0x12 sign_ext=1 -> 0xFFFFBEEF.
REQ-037 MEM_LATENCY=3, load -> stall high 2 cycles, valid_out 3 edges after acceptance; reset mid-BUSY -> IDLE, valid_out=0.
REQ-038 Word store at 0x22 -> misalign=1, word 0x20 unchanged on readback.
REQ-039 link=1, mem_data_in=0x408 -> rd_data_out=0x408; ALU op mem_address=0x55 -> rd_data_out=0x55.
REQ-040 DMEM_WB_BYPASS_EN on: rt_in=5, wb_rd=5, wb_we=1, wb_data=0x1234 -> stored word 0x1234; wb_rd=0 -> mem_data_in stored.
